// File: rtl/gf_mul_digit.sv
// -----------------------------------------------------------------------------
// gf_mul_digit
//   Digit-serial GF(2^WIDTH) multiplier. Computes out = in_1 * in_2 mod POLY
//   using MSB-first Horner evaluation, consuming DIGIT multiplier bits per
//   clock. A multiply takes N = WIDTH/DIGIT RUN cycles after the start edge.
//   Any legal DIGIT gives the same product for a given WIDTH and POLY; only
//   the latency changes.
//
// Parameters
//   WIDTH : field degree m, 2..16
//   POLY  : irreducible polynomial, WIDTH+1 bits, bit WIDTH set
//   DIGIT : multiplier bits per cycle, must divide WIDTH
//
// Ports
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   start : request a multiply (sampled only while idle)
//   in_1  : multiplicand a (captured on the start edge)
//   in_2  : multiplier b   (captured on the start edge)
//   out   : registered product, held until the next done
//   done  : one-cycle pulse marking a new out value
//   busy  : high while a multiply is in progress
// -----------------------------------------------------------------------------
module gf_mul_digit #(
  parameter int          WIDTH = 8,
  parameter int unsigned POLY  = 9'h11B,
  parameter int          DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] in_1,
  input  logic [WIDTH-1:0] in_2,
  output logic [WIDTH-1:0] out,
  output logic             done,
  output logic             busy
);

  // Guarded divisor so an illegal DIGIT=0 reports the error below instead of
  // failing on a divide-by-zero first.
  localparam int N  = WIDTH / ((DIGIT < 1) ? 1 : DIGIT);
  localparam int CW = $clog2(N + 1);
  localparam logic [WIDTH-1:0] POLY_LO = WIDTH'(POLY);

  // Refuse to elaborate an illegal field definition.
  if (WIDTH < 2 || WIDTH > 16 || DIGIT < 1 || (WIDTH % DIGIT) != 0 ||
      ((POLY >> WIDTH) & 1) != 1 || (POLY >> (WIDTH + 1)) != 0) begin : g_bad_params
    $error("gf_mul_digit: illegal parameters WIDTH=%0d POLY=%0h DIGIT=%0d",
           WIDTH, POLY, DIGIT);
  end

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, acc_q;
  logic [WIDTH-1:0] acc_n, b_n;
  logic [CW-1:0]    cnt_q;
  logic             last;

  // The counter is loaded with N, so the RUN edge that sees 1 is the final one.
  assign last = (cnt_q == CW'(1));

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the case leaves it unassigned, which would infer a latch.
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    busy = (state_q == RUN);
  end

  // ---------------------------------------------------------------------------
  // DIGIT unrolled Horner steps. Each step doubles acc (reducing when the bit
  // shifted out is set) and adds A if the current multiplier MSB is set.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: blocking assignments here are intentional -- each unrolled step
    // must see the value produced by the previous one within the same cycle.
    acc_n = acc_q;
    b_n   = b_q;
    for (int i = 0; i < DIGIT; i++) begin
      acc_n = {acc_n[WIDTH-2:0], 1'b0} ^ (acc_n[WIDTH-1] ? POLY_LO : '0);
      acc_n = acc_n ^ (b_n[WIDTH-1] ? a_q : '0);
      b_n   = {b_n[WIDTH-2:0], 1'b0};
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from the values present before the edge.
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      out   <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q   <= in_1;
            b_q   <= in_2;
            acc_q <= '0;
            cnt_q <= CW'(N);
          end
        end
        RUN: begin
          acc_q <= acc_n;
          b_q   <= b_n;
          cnt_q <= cnt_q - 1'b1;
          if (last) begin
            out  <= acc_n;
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gf_mul_digit.sv
// -----------------------------------------------------------------------------
// tb_gf_mul_digit
//   Self-checking bench for gf_mul_digit. A default-parameter instance runs a
//   table of hand-computed products plus back-to-back, start-while-busy and
//   mid-run reset sequences. Two WIDTH=4/POLY=5'h13 instances (DIGIT=2 and
//   DIGIT=1) are swept over all 256 operand pairs against a software model.
// -----------------------------------------------------------------------------
module tb_gf_mul_digit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] in_1, in_2;
  logic [7:0] out;
  logic       done, busy;

  logic       s4_start;
  logic [3:0] s4_a, s4_b;
  logic [3:0] out4_d2, out4_d1;
  logic       done4_d2, done4_d1, busy4_d2, busy4_d1;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  gf_mul_digit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_1(in_1), .in_2(in_2),
    .out(out), .done(done), .busy(busy)
  );

  gf_mul_digit #(.WIDTH(4), .POLY(5'h13), .DIGIT(2)) dut4_d2 (
    .clk(clk), .rst_n(rst_n), .start(s4_start), .in_1(s4_a), .in_2(s4_b),
    .out(out4_d2), .done(done4_d2), .busy(busy4_d2)
  );

  gf_mul_digit #(.WIDTH(4), .POLY(5'h13), .DIGIT(1)) dut4_d1 (
    .clk(clk), .rst_n(rst_n), .start(s4_start), .in_1(s4_a), .in_2(s4_b),
    .out(out4_d1), .done(done4_d1), .busy(busy4_d1)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // LSB-first shift-and-add reference multiplier.
  function automatic int gf_ref(input int a, input int b, input int w,
                                input int poly);
    int r = 0;
    int x = a;
    for (int i = 0; i < w; i++) begin
      if (((b >> i) & 1) == 1) r = r ^ x;
      x = x << 1;
      if (((x >> w) & 1) == 1) x = x ^ poly;
    end
    return r;
  endfunction

  // Issue one multiply on the default instance and wait (bounded) for done.
  // lat counts clock edges after the start edge; -1 means no done seen.
  task automatic do_mul(input logic [7:0] a, input logic [7:0] b,
                        output logic [7:0] res, output int lat,
                        output int busy_cyc);
    @(negedge clk);
    in_1  = a;
    in_2  = b;
    start = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    lat      = -1;
    busy_cyc = 0;
    res      = 'x;
    for (int k = 0; k < 40; k++) begin
      if (done) begin
        lat = k;
        res = out;
        break;
      end
      if (busy) busy_cyc++;
      @(negedge clk);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       vecs[10];
    logic [7:0] res;
    int         lat, busy_cyc;
    logic [7:0] pa[3], pb[3], pexp[3];
    int         t_done[3];

    vecs[0] = '{8'hE9, 8'h05, 8'h60};
    vecs[1] = '{8'h57, 8'h83, 8'hC1};
    vecs[2] = '{8'h53, 8'hCA, 8'h01};
    vecs[3] = '{8'h02, 8'h80, 8'h1B};
    vecs[4] = '{8'h57, 8'h13, 8'hFE};
    vecs[5] = '{8'h57, 8'h02, 8'hAE};
    vecs[6] = '{8'h01, 8'hA5, 8'hA5};
    vecs[7] = '{8'hFF, 8'h01, 8'hFF};
    vecs[8] = '{8'h00, 8'hFF, 8'h00};
    vecs[9] = '{8'hFF, 8'h00, 8'h00};

    rst_n    = 1'b0;
    start    = 1'b1;   // reset must win over start
    in_1     = 8'hE9;
    in_2     = 8'h05;
    s4_start = 1'b0;
    s4_a     = '0;
    s4_b     = '0;
    repeat (2) @(negedge clk);
    check("reset_out",  32'(out),  32'h0);
    check("reset_done", 32'(done), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'h0);

    // ---- table of directed products ----
    foreach (vecs[i]) begin
      do_mul(vecs[i].a, vecs[i].b, res, lat, busy_cyc);
      check($sformatf("vec%0d_out", i),  32'(res), 32'(vecs[i].exp));
      check($sformatf("vec%0d_lat", i),  32'(lat), 32'd8);
      check($sformatf("vec%0d_busy", i), 32'(busy_cyc), 32'd8);
      @(negedge clk);
      check($sformatf("vec%0d_done_pulse", i), 32'(done), 32'h0);
      check($sformatf("vec%0d_out_hold", i),   32'(out), 32'(vecs[i].exp));
    end

    // ---- back-to-back: each start issued in the predecessor's done cycle ----
    pa   = '{8'h57, 8'h53, 8'h02};
    pb   = '{8'h83, 8'hCA, 8'h80};
    pexp = '{8'hC1, 8'h01, 8'h1B};
    @(negedge clk);
    in_1  = pa[0];
    in_2  = pb[0];
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      t_done[i] = -1;
      res       = 'x;
      for (int t = 0; t < 40; t++) begin
        @(negedge clk);
        start = 1'b0;
        if (done) begin
          t_done[i] = cyc;
          res       = out;
          break;
        end
      end
      check($sformatf("b2b%0d_out", i), 32'(res), 32'(pexp[i]));
      if (i < 2) begin
        in_1  = pa[i+1];
        in_2  = pb[i+1];
        start = 1'b1;
      end
    end
    check("b2b_spacing_01", 32'(t_done[1] - t_done[0]), 32'd9);
    check("b2b_spacing_12", 32'(t_done[2] - t_done[1]), 32'd9);

    // ---- start while busy and operand toggling during RUN ----
    begin
      int n_done = 0;
      lat = -1;
      res = 'x;
      @(negedge clk);
      in_1  = 8'hE9;
      in_2  = 8'h05;
      start = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 20; k++) begin
        if (done) begin
          n_done++;
          res = out;
          lat = k;
        end
        in_1  = 8'($urandom);
        in_2  = 8'($urandom);
        start = (k == 3);
        if (k == 3) begin
          in_1 = 8'h57;
          in_2 = 8'h83;
        end
        @(negedge clk);
      end
      start = 1'b0;
      check("busy_start_ndone", 32'(n_done), 32'd1);
      check("busy_start_out",   32'(res),    32'h60);
      check("busy_start_lat",   32'(lat),    32'd8);
    end

    // ---- reset asserted mid-RUN ----
    begin
      int n_done = 0;
      @(negedge clk);
      in_1  = 8'hE9;
      in_2  = 8'h05;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check("midrst_out",  32'(out),  32'h0);
      check("midrst_done", 32'(done), 32'h0);
      check("midrst_busy", 32'(busy), 32'h0);
      rst_n = 1'b1;
      for (int k = 0; k < 12; k++) begin
        @(negedge clk);
        if (done) n_done++;
      end
      check("midrst_no_done", 32'(n_done), 32'd0);
      do_mul(8'hE9, 8'h05, res, lat, busy_cyc);
      check("postrst_out", 32'(res), 32'h60);
      check("postrst_lat", 32'(lat), 32'd8);
    end

    // ---- WIDTH=4 exhaustive sweep, DIGIT=2 and DIGIT=1 ----
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        logic [3:0] got2, got1;
        int         lat2, lat1;
        int         exp4;
        got2 = 'x;
        got1 = 'x;
        lat2 = -1;
        lat1 = -1;
        exp4 = gf_ref(a, b, 4, 'h13);
        @(negedge clk);
        s4_a     = 4'(a);
        s4_b     = 4'(b);
        s4_start = 1'b1;
        @(negedge clk);
        s4_start = 1'b0;
        for (int k = 0; k < 10; k++) begin
          if (done4_d2 && lat2 < 0) begin
            got2 = out4_d2;
            lat2 = k;
          end
          if (done4_d1 && lat1 < 0) begin
            got1 = out4_d1;
            lat1 = k;
          end
          if (lat2 >= 0 && lat1 >= 0) break;
          @(negedge clk);
        end
        check($sformatf("w4d2_%0h_%0h", a, b), 32'(got2), 32'(exp4));
        check($sformatf("w4d1_%0h_%0h", a, b), 32'(got1), 32'(exp4));
        if (a == 8 && b == 2) begin
          check("w4d2_8x2_out", 32'(got2), 32'h3);
          check("w4d2_8x2_lat", 32'(lat2), 32'd2);
          check("w4d1_8x2_lat", 32'(lat1), 32'd4);
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gf_mul_digit.md
GF_MUL_DIGIT -- requirements
Module: gf_mul_digit

Interface
REQ-001 SHALL have parameter WIDTH, default 8: field degree m of GF(2^m); legal values 2..16.
REQ-002 SHALL have parameter POLY, default 9'h11B: irreducible polynomial of WIDTH+1 bits, with bit WIDTH set.
REQ-003 SHALL have parameter DIGIT, default 1: multiplier bits consumed per cycle; must divide WIDTH.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-006 SHALL have port start, input, 1 bit: request a multiply; sampled only while idle.
REQ-007 SHALL have port in_1, input, WIDTH bits: multiplicand a.
REQ-008 SHALL have port in_2, input, WIDTH bits: multiplier b.
REQ-009 SHALL have port out, output, WIDTH bits: product a*b mod POLY, registered.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse marking a valid out.
REQ-011 SHALL have port busy, output, 1 bit: high while a multiply is in progress.

Function
REQ-012 SHALL elaborate only for legal parameters: 2<=WIDTH<=16, POLY[WIDTH]=1, POLY < 2^(WIDTH+1), WIDTH % DIGIT == 0. Any other set SHALL stop elaboration with an error.
REQ-013 SHALL implement a two-state FSM, IDLE and RUN, plus an iteration counter of ceil(log2(WIDTH/DIGIT+1)) bits.
REQ-014 In IDLE, a rising edge with start=1 SHALL:
  - capture in_1 into the A register and in_2 into the B register;
  - clear the accumulator;
  - load the counter with N = WIDTH/DIGIT;
  - enter RUN and set busy=1.
REQ-015 Each RUN edge SHALL apply DIGIT unrolled MSB-first Horner steps, each step being: acc = (acc<<1) reduced by POLY, XOR (b_msb ? A : 0), with B shifted left by one. The counter SHALL then decrement.
REQ-016 Reduction SHALL be conditional XOR with POLY[WIDTH-1:0] whenever the bit shifted out of acc is 1; the acc width SHALL always remain WIDTH bits.
REQ-017 On the RUN edge where the counter reaches 0, the block SHALL:
  - write the final acc to out;
  - assert done for exactly one cycle;
  - clear busy and return to IDLE.
REQ-018 Latency: start sampled at edge E0 gives done=1 and a valid out in the cycle after edge EN, with N=WIDTH/DIGIT (defaults: 8 cycles).
REQ-019 start SHALL be ignored while busy=1; operands and progress SHALL be unaffected.
REQ-020 start=1 in the cycle where done=1 SHALL be accepted, since the FSM is in IDLE. Back-to-back throughput is one result per N+1 cycles.
REQ-021 in_1 and in_2 SHALL be ignored after capture; changing them during RUN SHALL NOT alter the result.
REQ-022 out SHALL hold its last value until the next done; done=0 at all other times.
REQ-023 Operand 0 in either input SHALL yield out=0 with normal latency; there SHALL be no early termination.
REQ-024 Result SHALL be identical for every legal DIGIT at a fixed WIDTH/POLY; only latency changes.

Reset
REQ-025 rst_n=0 at a rising edge SHALL force state IDLE, counter=0, A=B=acc=0, out=0, done=0, busy=0, taking priority over start.
REQ-026 Reset asserted mid-RUN SHALL abort the operation with no done pulse. The first start after rst_n returns high SHALL behave as from power-up.
REQ-027 Outputs SHALL be undefined-free (no X) from the first reset edge onward.

Verification
REQ-028 Default params: start=1 one cycle with in_1=8'hE9, in_2=8'h05 -> busy high 8 cycles, then done pulse with out=8'h60.
REQ-029 Default params: pairs (8'h57,8'h83), (8'h53,8'hCA), (8'h02,8'h80) issued back-to-back, each start in its predecessor's done cycle -> out = 8'hC1, 8'h01, 8'h1B, spaced 9 cycles apart.
REQ-030 Default params: start pulsed again 3 cycles into RUN with different operands, and in_1/in_2 toggled during RUN -> single done, out equals the first pair's product.
REQ-031 Default params: rst_n=0 for one edge at cycle 4 of RUN -> no done, all outputs 0. A following start of (8'hE9,8'h05) -> out=8'h60 after 8 cycles.
REQ-032 WIDTH=4, POLY=5'h13, DIGIT=2: in_1=4'h8, in_2=4'h2 -> done after 2 cycles, out=4'h3. Exhaustive 256-pair sweep matches the DIGIT=1 build and a software model.
REQ-033 Operand zero (8'h00,8'hFF) and (8'hFF,8'h00) -> out=8'h00 after 8 cycles.
